// File: rtl/bcd_to_bin.sv
// ---------------------------------------------------------------------------
// bcd_to_bin
//
// Purpose:
//   Sequential converter from a three-digit BCD entry (hundreds, tens, ones)
//   to an 8-bit unsigned binary value. The entry is validated when it is
//   accepted. A legal entry is converted with a reverse double-dabble
//   datapath, which shifts right and subtracts 3 from any digit >= 8, over
//   eight SHIFT cycles. An illegal entry (a digit > 9 or a value > 255) is
//   reported through err on the cycle right after acceptance.
//
// Ports:
//   clk          in   1  system clock, rising-edge active
//   reset        in   1  synchronous, active-high reset (highest priority)
//   start        in   1  conversion request, only honoured in IDLE
//   BcdHundreds  in   4  hundreds digit
//   BcdTens      in   4  tens digit
//   BcdOnes      in   4  ones digit
//   Bit8Out      out  8  converted value, held until the next accepted start
//   busy         out  1  high while the SHIFT state is active
//   done         out  1  one-cycle pulse when Bit8Out/err are valid
//   err          out  1  illegal entry flag, held until the next accepted start
// ---------------------------------------------------------------------------
module bcd_to_bin (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] BcdHundreds,
    input  logic [3:0] BcdTens,
    input  logic [3:0] BcdOnes,
    output logic [7:0] Bit8Out,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_bcd;
    logic [11:0] w_bcd_nxt;
    logic [7:0]  r_bin;
    logic [7:0]  w_bin_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [7:0]  r_out;
    logic [7:0]  w_out_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_err;
    logic        w_err_nxt;

    logic [19:0] w_shifted;
    logic [11:0] w_shift_bcd;
    logic [7:0]  w_shift_bin;
    logic        w_entry_ok;

    // A digit that reads 8 or more after the right shift held a 10s carry from the digit above; remove the excess 3.
    function automatic logic [3:0] adj_digit(input logic [3:0] d);
        logic [3:0] r;
        if (d >= 4'd8) begin
            r = d - 4'd3;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // An entry is legal only if every digit is decimal and the value fits in 0..255.
    function automatic logic bcd_legal(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        logic v;
        if ((h > 4'd9) || (t > 4'd9) || (o > 4'd9)) begin
            v = 1'b0;
        end else if (h > 4'd2) begin
            v = 1'b0;
        end else if ((h == 4'd2) && (t > 4'd5)) begin
            v = 1'b0;
        end else if ((h == 4'd2) && (t == 4'd5) && (o > 4'd5)) begin
            v = 1'b0;
        end else begin
            v = 1'b1;
        end
        return v;
    endfunction

    // One reverse double-dabble step: shift {bcd, bin} right, then correct each BCD digit on its own.
    always_comb begin
        w_shifted   = {1'b0, r_bcd, r_bin[7:1]};
        w_shift_bcd = {adj_digit(w_shifted[19:16]),
                       adj_digit(w_shifted[15:12]),
                       adj_digit(w_shifted[11:8])};
        w_shift_bin = w_shifted[7:0];
        w_entry_ok  = bcd_legal(BcdHundreds, BcdTens, BcdOnes);
    end

    // Next-state and next-output logic; every register holds its value unless a state overrides it.
    always_comb begin
        w_state_nxt = r_state;
        w_bcd_nxt   = r_bcd;
        w_bin_nxt   = r_bin;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_err_nxt   = r_err;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_bcd_nxt = {BcdHundreds, BcdTens, BcdOnes};
                    w_bin_nxt = 8'd0;
                    w_cnt_nxt = 4'd0;
                    if (w_entry_ok) begin
                        w_state_nxt = ST_SHIFT;
                        w_busy_nxt  = 1'b1;
                        w_err_nxt   = 1'b0;
                    end else begin
                        // Illegal entry skips conversion and reports at once with a zero result.
                        w_state_nxt = ST_DONE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_out_nxt   = 8'd0;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_bcd_nxt = w_shift_bcd;
                w_bin_nxt = w_shift_bin;
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == 4'd7) begin
                    // The eighth shift completes the result; publish it directly from the shift output.
                    w_out_nxt   = w_shift_bin;
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_SHIFT;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset takes priority over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_bcd   <= 12'd0;
            r_bin   <= 8'd0;
            r_cnt   <= 4'd0;
            r_out   <= 8'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_bcd   <= w_bcd_nxt;
            r_bin   <= w_bin_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign Bit8Out = r_out;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule
